cdb_arbiter: RTL and testbench

- Collects completed results from all execute-stage functional units (ALU, multiplier, branch/address units) and serializes them onto the single-wide complete path.
- Produces the registered ex_ic_reg consumed by the complete stage, which drives the CDB and ROB complete.
- Buffers each FU's results in a small per-FU FIFO, grants one per cycle round-robin, and back-pressures FUs via per-FU ready.
- Squash (mispredict recovery) flushes all in-flight results.

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter_fu_fifo.sv | 64 ++++++
 rtl/cdb_arbiter.sv | 89 ++++++++
 tb/tb_cdb_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the execute-to-complete result arbiter.
package cdb_arbiter_pkg;

  localparam int NUM_FU        = 4;
  localparam int CDB_BUF_DEPTH = 2;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rob_idx;
    logic [31:0] result;
    logic [31:0] rs2_value;
    logic        take_branch;
    logic [5:0]  dest_tag;
  } EX_IC_PACKET;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result ports, squash, and registered complete-stage output of the CDB arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = cdb_arbiter_pkg::NUM_FU,
  parameter int BUF_DEPTH = cdb_arbiter_pkg::CDB_BUF_DEPTH
) ();

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic                         squash;
  logic [NUM_FU-1:0]            fu_valid;
  EX_IC_PACKET [NUM_FU-1:0]     fu_packet;
  logic [NUM_FU-1:0]            fu_ready;
  EX_IC_PACKET                  ex_ic_reg;
  logic [NUM_FU-1:0][CW-1:0]    fifo_count;

  modport master (
    output squash, fu_valid, fu_packet,
    input  fu_ready, ex_ic_reg, fifo_count
  );

  modport slave (
    input  squash, fu_valid, fu_packet,
    output fu_ready, ex_ic_reg, fifo_count
  );

endinterface

// File: rtl/cdb_arbiter_fu_fifo.sv
// Per-FU result FIFO; head visible combinationally, push/pop take effect at the edge.
// Push is ignored when full and pop when empty; clear empties it and wins over both.
module cdb_fu_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  EX_IC_PACKET   push_data,
  input  logic          pop,
  output EX_IC_PACKET   head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  EX_IC_PACKET   mem [BUF_DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    bump = (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CW'(BUF_DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full & ~clear;
  assign do_pop    = pop & ~empty & ~clear;
  assign head_data = mem[head_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= bump(tail_ptr);
      if (do_pop)  head_ptr <= bump(head_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone says what is live.
  always_ff @(posedge clock) begin
    if (do_push) mem[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Serializes FU results onto the single complete path via per-FU FIFOs and a round-robin grant.
// One-cycle minimum latency to ex_ic_reg; fu_ready comes from registered occupancy only.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = cdb_arbiter_pkg::NUM_FU,
  parameter int BUF_DEPTH = cdb_arbiter_pkg::CDB_BUF_DEPTH
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int RW = $clog2(NUM_FU);

  logic [NUM_FU-1:0]          push;
  logic [NUM_FU-1:0]          pop;
  logic [NUM_FU-1:0]          full;
  logic [NUM_FU-1:0]          empty;
  EX_IC_PACKET [NUM_FU-1:0]   head;
  logic [NUM_FU-1:0][CW-1:0]  count;

  logic [RW-1:0] rr_ptr;
  logic [RW-1:0] winner;
  logic [RW-1:0] rr_next;
  logic          found;
  EX_IC_PACKET   grant_pkt;
  EX_IC_PACKET   ex_ic_q;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    assign push[i] = bus.fu_valid[i] & ~full[i] & ~bus.squash;
    assign pop[i]  = found & (winner == RW'(i)) & ~bus.squash;

    cdb_fu_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear     (bus.squash),
      .push      (push[i]),
      .push_data (bus.fu_packet[i]),
      .pop       (pop[i]),
      .head_data (head[i]),
      .count     (count[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  assign bus.fu_ready   = ~full;
  assign bus.fifo_count = count;
  assign bus.ex_ic_reg  = ex_ic_q;

  // First non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_FU;
      if (!found && !empty[idx]) begin
        found  = 1'b1;
        winner = RW'(idx);
      end
    end
  end

  always_comb begin
    rr_next = (winner == RW'(NUM_FU - 1)) ? '0 : winner + 1'b1;
    grant_pkt       = head[winner];
    grant_pkt.valid = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      ex_ic_q <= '0;
    end else if (bus.squash) begin
      rr_ptr        <= '0;
      ex_ic_q.valid <= 1'b0;
    end else if (found) begin
      rr_ptr  <= rr_next;
      ex_ic_q <= grant_pkt;
    end else begin
      ex_ic_q.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin, back-pressure, squash, full push-pop.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   seq [4];
  logic [3:0] rdy_snap;

  cdb_arbiter_if #(.NUM_FU(4), .BUF_DEPTH(2)) bus ();

  cdb_arbiter #(.NUM_FU(4), .BUF_DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic EX_IC_PACKET mk(input int rob, input logic [31:0] res, input int tag);
    EX_IC_PACKET p;
    p             = '0;
    p.rob_idx     = 5'(rob);
    p.result      = res;
    p.dest_tag    = 6'(tag);
    p.rs2_value   = ~res;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.fu_valid = 4'b0000;
    for (int i = 0; i < 4; i++) bus.fu_packet[i] = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.squash = 1'b0;
    idle_inputs();

    // 1. asynchronous reset mid-cycle, then idle
    #3 reset = 1'b1;
    #1;
    check("rst_async_valid", 64'(bus.ex_ic_reg.valid), 64'd0);
    check("rst_async_count", 64'(bus.fifo_count), 64'd0);
    #8 reset = 1'b0;
    tick();
    check("rst_ready", 64'(bus.fu_ready), 64'hF);
    check("rst_rr", 64'(dut.rr_ptr), 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_valid", 64'(bus.ex_ic_reg.valid), 64'd0);
    end

    // 2. single result latency
    bus.fu_valid     = 4'b0100;
    bus.fu_packet[2] = mk(5, 32'hDEADBEEF, 12);
    tick();
    idle_inputs();
    check("lat_no_bypass", 64'(bus.ex_ic_reg.valid), 64'd0);
    check("lat_count2", 64'(bus.fifo_count[2]), 64'd1);
    tick();
    check("lat_valid", 64'(bus.ex_ic_reg.valid), 64'd1);
    check("lat_rob", 64'(bus.ex_ic_reg.rob_idx), 64'd5);
    check("lat_result", 64'(bus.ex_ic_reg.result), 64'hDEADBEEF);
    check("lat_tag", 64'(bus.ex_ic_reg.dest_tag), 64'd12);
    tick();
    check("lat_valid_drop", 64'(bus.ex_ic_reg.valid), 64'd0);

    // 3. round-robin, starting from rr_ptr = 0 after a squash
    bus.squash = 1'b1;
    tick();
    bus.squash = 1'b0;
    check("rr_squash_ptr", 64'(dut.rr_ptr), 64'd0);
    bus.fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) bus.fu_packet[i] = mk(i, 32'(i), i);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_valid", 64'(bus.ex_ic_reg.valid), 64'd1);
      check("rr_result", 64'(bus.ex_ic_reg.result), 64'(i));
    end
    check("rr_ptr_after", 64'(dut.rr_ptr), 64'd0);
    tick();
    check("rr_drain_valid", 64'(bus.ex_ic_reg.valid), 64'd0);

    // 4. back-pressure with every FU pushing whenever ready
    for (int i = 0; i < 4; i++) seq[i] = 0;
    for (int n = 1; n <= 13; n++) begin
      bus.fu_valid = 4'b1111;
      for (int i = 0; i < 4; i++)
        bus.fu_packet[i] = mk(i, 32'h1000 * i + 32'(seq[i]), i);
      rdy_snap = bus.fu_ready;
      tick();
      for (int i = 0; i < 4; i++) if (rdy_snap[i]) seq[i]++;
      if (n == 3) begin
        check("bp_count0_full", 64'(bus.fifo_count[0]), 64'd2);
        check("bp_ready0_low", 64'(bus.fu_ready[0]), 64'd0);
      end
      if (n >= 2) begin
        check("bp_valid", 64'(bus.ex_ic_reg.valid), 64'd1);
        check("bp_order", 64'(bus.ex_ic_reg.result),
              64'(32'h1000 * ((n - 2) % 4) + 32'((n - 2) / 4)));
      end
    end
    idle_inputs();
    bus.squash = 1'b1;
    tick();
    bus.squash = 1'b0;
    check("bp_cleared", 64'(bus.fifo_count), 64'd0);

    // 5. squash with counts {2,1,2,0} and all FUs presenting results
    bus.fu_valid     = 4'b0101;
    bus.fu_packet[0] = mk(1, 32'd1, 0);
    bus.fu_packet[2] = mk(3, 32'd3, 0);
    tick();
    bus.fu_valid     = 4'b0111;
    bus.fu_packet[0] = mk(4, 32'd4, 0);
    bus.fu_packet[1] = mk(2, 32'd2, 0);
    bus.fu_packet[2] = mk(6, 32'd6, 0);
    tick();
    check("sq_pre_out1", 64'(bus.ex_ic_reg.rob_idx), 64'd1);
    bus.fu_valid     = 4'b0011;
    bus.fu_packet[0] = mk(7, 32'd7, 0);
    bus.fu_packet[1] = mk(8, 32'd8, 0);
    tick();
    check("sq_pre_out2", 64'(bus.ex_ic_reg.rob_idx), 64'd2);
    check("sq_pre_counts", 64'(bus.fifo_count), 64'h26);
    bus.squash   = 1'b1;
    bus.fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) bus.fu_packet[i] = mk(20 + i, 32'(20 + i), 0);
    tick();
    bus.squash = 1'b0;
    idle_inputs();
    check("sq_counts", 64'(bus.fifo_count), 64'd0);
    check("sq_valid", 64'(bus.ex_ic_reg.valid), 64'd0);
    check("sq_rr", 64'(dut.rr_ptr), 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("sq_no_leak", 64'(bus.ex_ic_reg.valid), 64'd0);
    end

    // 6. push while FU2 is full and the only candidate
    bus.fu_valid     = 4'b0101;
    bus.fu_packet[0] = mk(11, 32'd11, 0);
    bus.fu_packet[2] = mk(9, 32'd9, 0);
    tick();
    bus.fu_valid     = 4'b0100;
    bus.fu_packet[0] = '0;
    bus.fu_packet[2] = mk(10, 32'd10, 0);
    tick();
    check("pp_out11", 64'(bus.ex_ic_reg.rob_idx), 64'd11);
    check("pp_full_count", 64'(bus.fifo_count), 64'h20);
    check("pp_ready_low", 64'(bus.fu_ready), 64'hB);
    bus.fu_packet[2] = mk(12, 32'd12, 0);
    tick();
    check("pp_out9", 64'(bus.ex_ic_reg.rob_idx), 64'd9);
    check("pp_count_after_pop", 64'(bus.fifo_count[2]), 64'd1);
    check("pp_ready_back", 64'(bus.fu_ready[2]), 64'd1);
    tick();
    idle_inputs();
    check("pp_out10", 64'(bus.ex_ic_reg.rob_idx), 64'd10);
    check("pp_count_pushpop", 64'(bus.fifo_count[2]), 64'd1);
    tick();
    check("pp_out12_valid", 64'(bus.ex_ic_reg.valid), 64'd1);
    check("pp_out12", 64'(bus.ex_ic_reg.rob_idx), 64'd12);
    check("pp_empty", 64'(bus.fifo_count), 64'd0);
    tick();
    check("pp_idle", 64'(bus.ex_ic_reg.valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
